sobel_filter: RTL and testbench



---
 rtl/sobel_filter.sv | 112 +++++++++++
 tb/tb_sobel_filter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_filter.sv
// Three-stage Sobel gradient: partial sums, absolute values and signs, then scaled magnitude
// with a four-way direction code. Each stage loads only when its incoming valid bit is set.
module sobel_filter #(
    parameter int MAG_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [71:0] sobel_data_in,
    input  logic        sobel_data_in_valid,
    output logic [7:0]  sobel_mag_out,
    output logic [1:0]  sobel_dir_out,
    output logic        sobel_out_valid
);

    logic [9:0] pix [9];

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
            assign pix[gi] = {2'b00, sobel_data_in[8*gi +: 8]};
        end
    endgenerate

    logic [2:0]  valid_reg;
    logic [9:0]  gx_pos_reg, gx_neg_reg, gy_pos_reg, gy_neg_reg;
    logic [9:0]  gx_pos_next, gx_neg_next, gy_pos_next, gy_neg_next;
    logic [9:0]  ax_reg, ay_reg, ax_next, ay_next;
    logic        sx_reg, sy_reg;
    logic [10:0] gx_s, gy_s, gx_inv, gy_inv;
    logic [10:0] sum, shifted;
    logic [19:0] ax_ext, ay_ext, ay_x256, ax_x106, ax_x618;
    logic [7:0]  mag_reg, mag_next;
    logic [1:0]  dir_reg, dir_next;

    // Stage 1: weighted sums of the three positive and three negative taps (max 1020 each).
    always_comb begin
        gx_pos_next = pix[2] + (pix[5] << 1) + pix[8];
        gx_neg_next = pix[0] + (pix[3] << 1) + pix[6];
        gy_pos_next = pix[6] + (pix[7] << 1) + pix[8];
        gy_neg_next = pix[0] + (pix[1] << 1) + pix[2];
    end

    // Stage 2: the 11-bit signed difference cannot overflow, so its magnitude fits in 10 bits.
    always_comb begin
        gx_s    = {1'b0, gx_pos_reg} - {1'b0, gx_neg_reg};
        gy_s    = {1'b0, gy_pos_reg} - {1'b0, gy_neg_reg};
        gx_inv  = -gx_s;
        gy_inv  = -gy_s;
        ax_next = gx_s[10] ? gx_inv[9:0] : gx_s[9:0];
        ay_next = gy_s[10] ? gy_inv[9:0] : gy_s[9:0];
    end

    // Stage 3: tan(22.5) ~ 106/256 and tan(67.5) ~ 618/256 set the direction sectors.
    always_comb begin
        sum      = {1'b0, ax_reg} + {1'b0, ay_reg};
        shifted  = sum >> MAG_SHIFT;
        mag_next = (shifted > 11'd255) ? 8'hFF : shifted[7:0];
        ax_ext   = {10'b0, ax_reg};
        ay_ext   = {10'b0, ay_reg};
        ay_x256  = ay_ext << 8;
        ax_x106  = ax_ext * 20'd106;
        ax_x618  = ax_ext * 20'd618;
        dir_next = 2'd0;
        if (ay_x256 <= ax_x106) begin
            dir_next = 2'd0;
        end else if (ay_x256 >= ax_x618) begin
            dir_next = 2'd2;
        end else if (ax_reg != 10'd0 && ay_reg != 10'd0 && sx_reg == sy_reg) begin
            dir_next = 2'd1;
        end else begin
            dir_next = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_reg  <= 3'b000;
            gx_pos_reg <= '0;
            gx_neg_reg <= '0;
            gy_pos_reg <= '0;
            gy_neg_reg <= '0;
            ax_reg     <= '0;
            ay_reg     <= '0;
            sx_reg     <= 1'b0;
            sy_reg     <= 1'b0;
            mag_reg    <= '0;
            dir_reg    <= '0;
        end else begin
            valid_reg <= {valid_reg[1:0], sobel_data_in_valid};
            if (sobel_data_in_valid) begin
                gx_pos_reg <= gx_pos_next;
                gx_neg_reg <= gx_neg_next;
                gy_pos_reg <= gy_pos_next;
                gy_neg_reg <= gy_neg_next;
            end
            if (valid_reg[0]) begin
                ax_reg <= ax_next;
                ay_reg <= ay_next;
                sx_reg <= gx_s[10];
                sy_reg <= gy_s[10];
            end
            if (valid_reg[1]) begin
                mag_reg <= mag_next;
                dir_reg <= dir_next;
            end
        end
    end

    assign sobel_mag_out   = mag_reg;
    assign sobel_dir_out   = dir_reg;
    assign sobel_out_valid = valid_reg[2];

endmodule

// File: tb/tb_sobel_filter.sv
// Bench for sobel_filter: directed vector table, gap/reset sequences and random windows,
// checked through a cycle-stamped scoreboard against a behavioural model.
`timescale 1ns/1ps
module tb_sobel_filter;

    logic        clk = 1'b0;
    logic        rstN;
    logic [71:0] data;
    logic        in_valid;
    logic [7:0]  mag, mag_sat;
    logic [1:0]  dir, dir_sat;
    logic        out_valid, out_valid_sat;

    always #5 clk = ~clk;

    sobel_filter #(.MAG_SHIFT(3)) dut (
        .clk(clk), .rstN(rstN), .sobel_data_in(data), .sobel_data_in_valid(in_valid),
        .sobel_mag_out(mag), .sobel_dir_out(dir), .sobel_out_valid(out_valid)
    );

    sobel_filter #(.MAG_SHIFT(0)) dut_sat (
        .clk(clk), .rstN(rstN), .sobel_data_in(data), .sobel_data_in_valid(in_valid),
        .sobel_mag_out(mag_sat), .sobel_dir_out(dir_sat), .sobel_out_valid(out_valid_sat)
    );

    typedef struct {
        logic [7:0] mag;
        logic [7:0] mag0;
        logic [1:0] dir;
        int         cyc;
    } sb_t;

    typedef struct {
        logic [71:0] win;
        logic [7:0]  mag;
        logic [7:0]  mag0;
        logic [1:0]  dir;
    } vec_t;

    sb_t        q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fails = 0;
    int         n_txn = 0;
    logic [7:0] last_mag = 0, last_mag0 = 0;
    logic [1:0] last_dir = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [71:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        pk = {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    function automatic void model(input logic [71:0] w, input int sh,
                                  output logic [7:0] m, output logic [1:0] d);
        int p[9];
        int gx, gy, ax, ay, s;
        for (int i = 0; i < 9; i++) p[i] = int'(w[8*i +: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        s  = (ax + ay) >> sh;
        m  = (s > 255) ? 8'd255 : 8'(s);
        if (256*ay <= 106*ax)                      d = 2'd0;
        else if (256*ay >= 618*ax)                 d = 2'd2;
        else if ((gx > 0 && gy > 0) || (gx < 0 && gy < 0)) d = 2'd1;
        else                                       d = 2'd3;
    endfunction

    task automatic drive(input logic [71:0] w, input logic [7:0] m, input logic [7:0] m0,
                         input logic [1:0] d);
        sb_t e;
        @(negedge clk);
        data     = w;
        in_valid = 1'b1;
        e.mag = m; e.mag0 = m0; e.dir = d; e.cyc = cyc + 3;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        data     = {8'($urandom), 32'($urandom), 32'($urandom)};
    endtask

    task automatic drive_rand(input bit edgy);
        logic [71:0] w;
        logic [7:0]  m, m0;
        logic [1:0]  d, d0;
        for (int i = 0; i < 9; i++) begin
            if (edgy) w[8*i +: 8] = ($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0;
            else      w[8*i +: 8] = 8'($urandom_range(0, 255));
        end
        model(w, 3, m, d);
        model(w, 0, m0, d0);
        drive(w, m, m0, d);
    endtask

    // Output monitor: one comparison of valid per cycle, plus data or hold checks.
    always @(posedge clk) begin
        bit exp_v;
        sb_t e;
        #1;
        cyc = cyc + 1;
        exp_v = (q.size() > 0) && (q[0].cyc == cyc);
        chk(out_valid == exp_v, "out_valid", int'(out_valid), int'(exp_v));
        chk(out_valid_sat == exp_v, "out_valid_sat", int'(out_valid_sat), int'(exp_v));
        if (exp_v) begin
            e = q.pop_front();
            if (out_valid) begin
                chk(mag == e.mag, "mag", int'(mag), int'(e.mag));
                chk(dir == e.dir, "dir", int'(dir), int'(e.dir));
                chk(mag_sat == e.mag0, "mag_shift0", int'(mag_sat), int'(e.mag0));
                chk(dir_sat == e.dir, "dir_shift0", int'(dir_sat), int'(e.dir));
                n_txn++;
                $display("txn %0d cycle %0d mag %0d dir %0d mag_shift0 %0d",
                         n_txn, cyc, mag, dir, mag_sat);
            end
            last_mag = e.mag; last_mag0 = e.mag0; last_dir = e.dir;
        end else if (!out_valid) begin
            chk(mag == last_mag, "hold_mag", int'(mag), int'(last_mag));
            chk(dir == last_dir, "hold_dir", int'(dir), int'(last_dir));
            chk(mag_sat == last_mag0, "hold_mag_shift0", int'(mag_sat), int'(last_mag0));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{pk(100,100,100,100,100,100,100,100,100), 8'd0,   8'd0,   2'd0};
        vecs[1]  = '{pk(0,128,255, 0,128,255, 0,128,255),     8'd127, 8'd255, 2'd0};
        vecs[2]  = '{pk(0,0,0, 50,50,50, 255,255,255),        8'd127, 8'd255, 2'd2};
        vecs[3]  = '{pk(0,0,0, 0,0,0, 0,0,255),               8'd63,  8'd255, 2'd1};
        vecs[4]  = '{pk(0,0,0, 0,0,0, 255,0,0),               8'd63,  8'd255, 2'd3};
        vecs[5]  = '{pk(0,0,0, 0,0,255, 0,0,0),               8'd63,  8'd255, 2'd0};
        vecs[6]  = '{pk(0,255,0, 0,0,0, 0,0,0),               8'd63,  8'd255, 2'd2};
        vecs[7]  = '{pk(0,0,0, 0,0,0, 0,0,0),                 8'd0,   8'd0,   2'd0};
        vecs[8]  = '{pk(255,0,0, 0,0,0, 0,0,0),               8'd63,  8'd255, 2'd1};
        vecs[9]  = '{pk(0,0,1, 0,0,0, 0,0,0),                 8'd0,   8'd2,   2'd3};
        vecs[10] = '{pk(0,0,0, 0,0,128, 0,53,0),              8'd45,  8'd255, 2'd0};
        vecs[11] = '{pk(0,0,0, 0,0,128, 0,54,0),              8'd45,  8'd255, 2'd1};
        vecs[12] = '{pk(0,0,0, 0,0,74, 0,255,108),            8'd109, 8'd255, 2'd2};
        vecs[13] = '{pk(0,0,0, 0,0,74, 0,254,108),            8'd109, 8'd255, 2'd1};

        rstN = 1'b0; in_valid = 1'b0; data = '0;
        repeat (3) @(negedge clk);
        chk(out_valid == 1'b0, "reset_valid", int'(out_valid), 0);
        chk(mag == 8'd0, "reset_mag", int'(mag), 0);
        chk(dir == 2'd0, "reset_dir", int'(dir), 0);
        rstN = 1'b1;

        foreach (vecs[i]) drive(vecs[i].win, vecs[i].mag, vecs[i].mag0, vecs[i].dir);
        repeat (5) idle();

        // Burst of ten, two-cycle gap with junk data, burst of five.
        repeat (10) drive_rand(1'b0);
        repeat (2) idle();
        repeat (5) drive_rand(1'b0);
        repeat (5) idle();

        // Reset with two windows still inside the pipe.
        drive(vecs[1].win, vecs[1].mag, vecs[1].mag0, vecs[1].dir);
        drive(vecs[3].win, vecs[3].mag, vecs[3].mag0, vecs[3].dir);
        drive(vecs[4].win, vecs[4].mag, vecs[4].mag0, vecs[4].dir);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rstN = 1'b0;
        q.delete();
        last_mag = 0; last_mag0 = 0; last_dir = 0;
        #1;
        chk(out_valid == 1'b0, "async_reset_valid", int'(out_valid), 0);
        chk(mag == 8'd0, "async_reset_mag", int'(mag), 0);
        chk(dir == 2'd0, "async_reset_dir", int'(dir), 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (6) idle();
        drive(vecs[2].win, vecs[2].mag, vecs[2].mag0, vecs[2].dir);
        repeat (5) idle();

        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) == 0) idle();
            else drive_rand($urandom_range(0, 3) == 0);
        end
        repeat (6) idle();
        chk(q.size() == 0, "scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
